// File: rtl/alt_det_pkg.sv
// Shared state encoding and saturating-increment helper for the alternating-run detector.
`timescale 1ns/1ps
package alt_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LAST0 = 2'd1,
    ST_LAST1 = 2'd2
  } state_e;

  // Increment value, holding at the all-ones value of a width-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Registered saturating counter with synchronous clear and load-to-one.
`timescale 1ns/1ps
module sat_counter
  import alt_det_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load1_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear beats load-to-one, which beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = W'(1);
    end else if (inc_i) begin
      cnt_d = W'(sat_inc(32'(cnt_q), W));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/alt_run_detector.sv
// Serial alternating-bit run detector: tracks run length, pulses z on a hit, counts hits.
`timescale 1ns/1ps
module alt_run_detector
  import alt_det_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 4,
  parameter int OVERLAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             clr,
  output logic             z,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] hit_cnt
);

  if (RUN_LEN < 2 || RUN_LEN > (1 << CNT_W) - 1) begin : g_bad_run_len
    $error("alt_run_detector: RUN_LEN %0d out of range for CNT_W %0d", RUN_LEN, CNT_W);
  end

  state_e           state_q, state_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] run_len_q;
  logic [CNT_W-1:0] run_next;
  logic             run_clr, run_load1, run_inc;
  logic             hit;

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (run_clr),
    .load1_i (run_load1),
    .inc_i   (run_inc),
    .cnt_o   (run_len_q)
  );

  always_comb begin
    state_d   = state_q;
    z_d       = 1'b0;
    run_clr   = clr;
    run_load1 = 1'b0;
    run_inc   = 1'b0;
    run_next  = run_len_q;
    hit       = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
    end else if (x_valid) begin
      state_d = x ? ST_LAST1 : ST_LAST0;
      if ((state_q == ST_LAST0 && x) || (state_q == ST_LAST1 && !x)) begin
        run_inc  = 1'b1;
        run_next = CNT_W'(sat_inc(32'(run_len_q), CNT_W));
      end else begin
        // IDLE, a repeated bit, or an unused encoding all start a fresh run.
        run_load1 = 1'b1;
        run_next  = CNT_W'(1);
      end
      if (OVERLAP != 0) begin
        hit = (run_next >= CNT_W'(RUN_LEN));
      end else begin
        hit = (run_next == CNT_W'(RUN_LEN));
        if (hit) begin
          state_d = ST_IDLE;
          run_clr = 1'b1;
        end
      end
      z_d = hit;
    end
    hit_cnt_d = clr ? '0 : hit_cnt_q + CNT_W'(z_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      z_q       <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      z_q       <= z_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign z       = z_q;
  assign run_len = run_len_q;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_alt_run_detector.sv
// Scoreboard bench for alt_run_detector: three parameterisations driven from directed vectors.
`timescale 1ns/1ps
module tb_alt_run_detector;

  logic clk;
  logic rst;
  logic x_s  [3];
  logic xv_s [3];
  logic clr_s[3];

  logic       z_ov, z_no, z_sat;
  logic [3:0] len_ov, hit_ov, len_no, hit_no;
  logic [2:0] len_sat, hit_sat;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  typedef struct {
    int    sel;
    logic  z;
    int    len;
    int    hit;
    string nm;
  } exp_t;

  exp_t exp_q[$];

  // 0: overlapping RUN_LEN=4, 1: restart-after-hit, 2: CNT_W=3 RUN_LEN=2 overlapping
  alt_run_detector #(.RUN_LEN(4), .CNT_W(4), .OVERLAP(1)) u_ov (
    .clk(clk), .rst(rst), .x(x_s[0]), .x_valid(xv_s[0]), .clr(clr_s[0]),
    .z(z_ov), .run_len(len_ov), .hit_cnt(hit_ov));

  alt_run_detector #(.RUN_LEN(4), .CNT_W(4), .OVERLAP(0)) u_no (
    .clk(clk), .rst(rst), .x(x_s[1]), .x_valid(xv_s[1]), .clr(clr_s[1]),
    .z(z_no), .run_len(len_no), .hit_cnt(hit_no));

  alt_run_detector #(.RUN_LEN(2), .CNT_W(3), .OVERLAP(1)) u_sat (
    .clk(clk), .rst(rst), .x(x_s[2]), .x_valid(xv_s[2]), .clr(clr_s[2]),
    .z(z_sat), .run_len(len_sat), .hit_cnt(hit_sat));

  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  task automatic check(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      xv_s[i]  = 1'b0;
      clr_s[i] = 1'b0;
    end
  endtask

  task automatic step(input int sel, input logic xv, input logic xb, input logic c,
                      input logic ez, input int elen, input int ehit, input string nm);
    exp_t e;
    @(negedge clk);
    idle_all();
    x_s[sel]   = xb;
    xv_s[sel]  = xv;
    clr_s[sel] = c;
    e.sel = sel; e.z = ez; e.len = elen; e.hit = ehit; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic check_dut(input int sel, input logic ez, input int elen, input int ehit,
                           input string nm);
    int az, al, ah;
    case (sel)
      0:       begin az = int'(z_ov);  al = int'(len_ov);  ah = int'(hit_ov);  end
      1:       begin az = int'(z_no);  al = int'(len_no);  ah = int'(hit_no);  end
      default: begin az = int'(z_sat); al = int'(len_sat); ah = int'(hit_sat); end
    endcase
    $display("[%0t] dut%0d %s: z=%0d run_len=%0d hit_cnt=%0d", $time, sel, nm, az, al, ah);
    check({nm, ".z"}, az, int'(ez));
    check({nm, ".run_len"}, al, elen);
    check({nm, ".hit_cnt"}, ah, ehit);
  endtask

  // Monitor: the DUT presents a result one edge after each issued sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_dut(e.sel, e.z, e.len, e.hit, e.nm);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 50000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) x_s[i] = 1'b0;
    idle_all();

    // Reset behaviour, sampled while rst is held low.
    #1 rst = 1'b0;
    #1.5;
    for (int s = 0; s < 3; s++) check_dut(s, 1'b0, 0, 0, "reset");
    #0.5 rst = 1'b1;

    // Overlapping run 0,1,0,1,0.
    step(0, 1, 0, 0, 0, 1, 0, "ov_b1");
    step(0, 1, 1, 0, 0, 2, 0, "ov_b2");
    step(0, 1, 0, 0, 0, 3, 0, "ov_b3");
    step(0, 1, 1, 0, 1, 4, 1, "ov_b4");
    step(0, 1, 0, 0, 1, 5, 2, "ov_b5");

    // Restart-after-hit: hits at bits 4 and 8, then a fresh run ignores the hit bit.
    step(1, 1, 0, 0, 0, 1, 0, "no_b1");
    step(1, 1, 1, 0, 0, 2, 0, "no_b2");
    step(1, 1, 0, 0, 0, 3, 0, "no_b3");
    step(1, 1, 1, 0, 1, 0, 1, "no_b4");
    step(1, 1, 0, 0, 0, 1, 1, "no_b5");
    step(1, 1, 1, 0, 0, 2, 1, "no_b6");
    step(1, 1, 0, 0, 0, 3, 1, "no_b7");
    step(1, 1, 1, 0, 1, 0, 2, "no_b8");
    step(1, 1, 1, 0, 0, 1, 2, "no_fresh");
    step(1, 1, 1, 0, 0, 1, 2, "no_repeat");
    step(1, 1, 0, 0, 0, 2, 2, "no_alt");

    // Repeated bit restarts the run; invalid cycles hold state.
    step(0, 0, 0, 1, 0, 0, 0, "ov_clr");
    step(0, 1, 0, 0, 0, 1, 0, "rep_b1");
    step(0, 1, 1, 0, 0, 2, 0, "rep_b2");
    step(0, 1, 1, 0, 0, 1, 0, "rep_b3");
    step(0, 1, 0, 0, 0, 2, 0, "rep_b4");
    step(0, 1, 1, 0, 0, 3, 0, "rep_b5");
    step(0, 1, 0, 0, 1, 4, 1, "rep_b6");
    step(0, 0, 1, 0, 0, 4, 1, "hold1");
    step(0, 0, 0, 0, 0, 4, 1, "hold2");
    step(0, 0, 1, 0, 0, 4, 1, "hold3");
    step(0, 1, 1, 0, 1, 5, 2, "resume");

    // Saturation at 7 and hit_cnt wrap with CNT_W=3, RUN_LEN=2.
    for (int i = 0; i < 10; i++) begin
      step(2, 1, logic'(i % 2), 0, logic'(i >= 1), (i + 1 > 7) ? 7 : i + 1, i % 8,
           $sformatf("sat_b%0d", i + 1));
    end

    // Reset mid-run, then clr with a simultaneous valid sample.
    step(0, 0, 0, 1, 0, 0, 0, "pre_clr");
    step(0, 1, 0, 0, 0, 1, 0, "mr_b1");
    step(0, 1, 1, 0, 0, 2, 0, "mr_b2");
    step(0, 1, 0, 0, 0, 3, 0, "mr_b3");
    @(negedge clk);
    idle_all();
    rst = 1'b0;
    #1 check_dut(0, 1'b0, 0, 0, "midrun_rst");
    @(negedge clk);
    rst = 1'b1;
    step(0, 1, 1, 0, 0, 1, 0, "post_rst_b1");
    step(0, 1, 0, 0, 0, 2, 0, "post_rst_b2");
    step(0, 1, 1, 0, 0, 3, 0, "post_rst_b3");
    step(0, 1, 0, 0, 1, 4, 1, "post_rst_b4");
    step(0, 1, 1, 1, 0, 0, 0, "clr_drop");
    step(0, 1, 1, 0, 0, 1, 0, "after_clr");

    @(negedge clk);
    idle_all();
    repeat (3) @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
